// File: rtl/par_pkg.sv
// Shared types for the UART parity generator/checker: parity modes, RX FSM
// states and the parity-bit function used by both the TX and RX paths.
package par_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCUM    = 2'b01,
    ST_WAIT_PAR = 2'b10
  } rx_state_e;

  typedef struct packed {
    logic     en;
    par_typ_e typ;
  } par_mode_t;

  // dpar is the XOR reduction of the data bits.
  function automatic logic par_calc(input logic dpar, input par_typ_e typ);
    case (typ)
      PAR_EVEN: return dpar;
      PAR_ODD:  return ~dpar;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/par_chk_fsm.sv
// RX parity checker: accumulates parity over the serial data bits of one
// frame and compares it with the received parity bit.
module par_chk_fsm
  import par_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      rx_start,
  input  logic      rx_bit,
  input  logic      rx_bit_vld,
  input  logic      rx_par_vld,
  input  par_mode_t mode,
  output logic      par_err,
  output logic      frm_err,
  output logic      par_err_set
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  rx_state_e     state, state_nxt;
  logic          acc, acc_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  par_mode_t     rx_mode, rx_mode_nxt;
  logic          par_err_nxt, frm_err_nxt;

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    bit_cnt_nxt = bit_cnt;
    rx_mode_nxt = rx_mode;
    par_err_nxt = 1'b0;
    frm_err_nxt = 1'b0;
    if (rx_start) begin
      state_nxt   = ST_ACCUM;
      acc_nxt     = 1'b0;
      bit_cnt_nxt = '0;
      rx_mode_nxt = mode;
    end else begin
      case (state)
        ST_ACCUM: begin
          // A parity strobe here means the frame ended before DATA_WIDTH bits.
          if (rx_par_vld) begin
            frm_err_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else if (rx_bit_vld) begin
            acc_nxt     = acc ^ rx_bit;
            bit_cnt_nxt = bit_cnt + CW'(1);
            if (bit_cnt == LAST_IDX)
              state_nxt = rx_mode.en ? ST_WAIT_PAR : ST_IDLE;
          end
        end
        ST_WAIT_PAR: begin
          if (rx_par_vld) begin
            par_err_nxt = (rx_bit != par_calc(acc, rx_mode.typ));
            state_nxt   = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      acc     <= 1'b0;
      bit_cnt <= '0;
      rx_mode <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      bit_cnt <= bit_cnt_nxt;
      rx_mode <= rx_mode_nxt;
      par_err <= par_err_nxt;
      frm_err <= frm_err_nxt;
    end
  end

  assign par_err_set = par_err_nxt;

endmodule

// File: rtl/par_gen_chk.sv
// UART parity generator/checker: registered TX parity bit, RX parity check
// and a saturating parity-error counter.
module par_gen_chk
  import par_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     par_en,
  input  logic [1:0]               par_typ,
  input  logic [DATA_WIDTH-1:0]    p_data,
  input  logic                     data_valid,
  input  logic                     busy,
  output logic                     par_bit,
  output logic                     par_vld,
  input  logic                     rx_start,
  input  logic                     rx_bit,
  input  logic                     rx_bit_vld,
  input  logic                     rx_par_vld,
  output logic                     par_err,
  output logic                     frm_err,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  par_mode_t mode;
  logic      par_err_set;

  assign mode = '{en: par_en, typ: par_typ_e'(par_typ)};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit <= 1'b0;
      par_vld <= 1'b0;
    end else begin
      par_vld <= data_valid && !busy;
      if (data_valid && !busy)
        par_bit <= par_en ? par_calc(^p_data, mode.typ) : 1'b0;
    end
  end

  par_chk_fsm #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .CLK        (CLK),
    .RST        (RST),
    .rx_start   (rx_start),
    .rx_bit     (rx_bit),
    .rx_bit_vld (rx_bit_vld),
    .rx_par_vld (rx_par_vld),
    .mode       (mode),
    .par_err    (par_err),
    .frm_err    (frm_err),
    .par_err_set(par_err_set)
  );

  // Counts on the combinational error flag so err_cnt moves with par_err.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (par_err_set && (err_cnt != '1))
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_par_gen_chk.sv
// Directed self-checking bench for par_gen_chk.
module tb_par_gen_chk;

  logic       CLK = 1'b0;
  logic       RST;
  logic       par_en;
  logic [1:0] par_typ;
  logic [7:0] p_data;
  logic       data_valid, busy;
  logic       par_bit, par_vld;
  logic       rx_start, rx_bit, rx_bit_vld, rx_par_vld;
  logic       par_err, frm_err;
  logic       err_clr;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  par_gen_chk #(
    .DATA_WIDTH   (8),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .p_data    (p_data),
    .data_valid(data_valid),
    .busy      (busy),
    .par_bit   (par_bit),
    .par_vld   (par_vld),
    .rx_start  (rx_start),
    .rx_bit    (rx_bit),
    .rx_bit_vld(rx_bit_vld),
    .rx_par_vld(rx_par_vld),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_begin();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic rx_bits(input logic [7:0] data, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      rx_bit     = data[i];
      rx_bit_vld = 1'b1;
      tick();
    end
    rx_bit_vld = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic rx_parity(input logic b);
    rx_bit     = b;
    rx_par_vld = 1'b1;
    tick();
    rx_par_vld = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic tx_cap(input logic en, input logic [1:0] typ, input logic [7:0] d);
    par_en     = en;
    par_typ    = typ;
    p_data     = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b0; par_en = 1'b0; par_typ = 2'b00; p_data = '0;
    data_valid = 1'b0; busy = 1'b0; rx_start = 1'b0; rx_bit = 1'b0;
    rx_bit_vld = 1'b0; rx_par_vld = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_par_bit", par_bit, 0);
    check("rst_par_vld", par_vld, 0);
    check("rst_par_err", par_err, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    RST = 1'b1;
    tick();

    // TX generation
    tx_cap(1'b1, 2'b00, 8'hA5);
    check("tx_even_a5", par_bit, 0);
    check("tx_even_a5_vld", par_vld, 1);
    tx_cap(1'b1, 2'b01, 8'hA5);
    check("tx_odd_a5", par_bit, 1);
    tx_cap(1'b1, 2'b00, 8'h07);
    check("tx_even_07", par_bit, 1);
    tx_cap(1'b1, 2'b11, 8'h07);
    check("tx_space", par_bit, 0);
    tx_cap(1'b1, 2'b10, 8'h00);
    check("tx_mark", par_bit, 1);
    tick();
    check("tx_vld_one_cycle", par_vld, 0);
    busy = 1'b1;
    tx_cap(1'b1, 2'b11, 8'h00);
    check("tx_busy_hold", par_bit, 1);
    check("tx_busy_no_vld", par_vld, 0);
    busy = 1'b0;
    tx_cap(1'b0, 2'b10, 8'h07);
    check("tx_none", par_bit, 0);
    check("tx_none_vld", par_vld, 1);

    // RX good frame: even, 0x07, parity 1
    par_en = 1'b1; par_typ = 2'b00;
    rx_begin();
    rx_bits(8'h07, 8);
    rx_parity(1'b1);
    check("rx_good_par_err", par_err, 0);
    check("rx_good_frm_err", frm_err, 0);
    check("rx_good_cnt", err_cnt, 0);

    // RX bad frame: odd, 0xA5, parity 0
    par_typ = 2'b01;
    rx_begin();
    rx_bits(8'hA5, 8);
    rx_parity(1'b0);
    check("rx_bad_par_err", par_err, 1);
    check("rx_bad_cnt", err_cnt, 1);
    tick();
    check("rx_bad_pulse_end", par_err, 0);

    // Saturation: 259 more bad frames
    for (int i = 0; i < 259; i++) begin
      rx_begin();
      rx_bits(8'hA5, 8);
      rx_parity(1'b0);
    end
    check("sat_cnt", err_cnt, 255);

    // err_clr coincident with par_err
    rx_begin();
    rx_bits(8'hA5, 8);
    err_clr = 1'b1;
    rx_parity(1'b0);
    err_clr = 1'b0;
    check("clr_par_err", par_err, 1);
    check("clr_cnt", err_cnt, 0);

    // Short frame
    par_typ = 2'b00;
    rx_begin();
    rx_bits(8'h1F, 5);
    rx_parity(1'b1);
    check("short_frm_err", frm_err, 1);
    check("short_par_err", par_err, 0);
    tick();
    check("short_pulse_end", frm_err, 0);

    // Parity disabled: FSM back to IDLE after 8th bit, later strobe ignored
    par_en = 1'b0;
    rx_begin();
    rx_bits(8'hA5, 8);
    rx_parity(1'b1);
    check("none_par_err", par_err, 0);
    check("none_frm_err", frm_err, 0);
    par_en = 1'b1;

    // Restart after 4 bits, then fresh 0x07 even with parity 1
    rx_begin();
    rx_bits(8'h01, 4);
    rx_begin();
    rx_bits(8'h07, 8);
    rx_parity(1'b1);
    check("restart_par_err", par_err, 0);
    check("restart_frm_err", frm_err, 0);

    // Mode latched at start: odd, 0xA5 expects 1; switch to even mid-frame
    par_typ = 2'b01;
    rx_begin();
    rx_bits(8'hA5, 4);
    par_typ = 2'b00;
    rx_bits(8'h0A, 4);
    rx_parity(1'b1);
    check("latched_mode_par_err", par_err, 0);

    // Extra data bit in WAIT_PAR ignored; parity strobe wins over same-cycle bit strobe
    rx_begin();
    rx_bits(8'h07, 8);
    rx_bits(8'h01, 1);
    rx_bit = 1'b1; rx_bit_vld = 1'b1; rx_par_vld = 1'b1;
    tick();
    rx_bit = 1'b0; rx_bit_vld = 1'b0; rx_par_vld = 1'b0;
    check("both_strobe_par_err", par_err, 0);
    check("both_strobe_frm_err", frm_err, 0);
    check("both_strobe_cnt", err_cnt, 0);

    // Bad frame to make err_cnt nonzero, mark parity on TX, then reset mid-frame
    par_typ = 2'b01;
    rx_begin();
    rx_bits(8'hA5, 8);
    rx_parity(1'b0);
    check("pre_rst_cnt", err_cnt, 1);
    tx_cap(1'b1, 2'b10, 8'h00);
    check("pre_rst_par_bit", par_bit, 1);
    rx_begin();
    rx_bits(8'hA5, 3);
    RST = 1'b0;
    #2;
    check("midrst_par_bit", par_bit, 0);
    check("midrst_cnt", err_cnt, 0);
    check("midrst_par_err", par_err, 0);
    tick();
    RST = 1'b1;
    rx_bits(8'hFF, 5);
    rx_parity(1'b0);
    check("post_rst_par_err", par_err, 0);
    check("post_rst_frm_err", frm_err, 0);
    check("post_rst_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
